// File: rtl/ram_sinc_param.sv
`default_nettype none
// ============================================================================
// Module   : ram_sinc_param
// Purpose  : Parametrised single-port synchronous scratch RAM. It has a
//            registered read with a valid flag, out-of-range detection and an
//            init sequencer that loads a descending pattern after every reset.
// Ports    : clk        - clock, rising edge
//            rst        - asynchronous reset, active high
//            EN         - write enable
//            RE         - read enable
//            direccion  - word address, shared by read and write
//            Dato_E     - write data
//            dato_s     - registered read data
//            valid      - dato_s holds the result of the previous cycle's read
//            err        - previous cycle's accepted access was out of range
//            busy       - init sweep in progress, accesses are ignored
// Revision : 1.0 - initial release
// ============================================================================
module ram_sinc_param #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int DEPTH      = 11,
    parameter int INIT_BASE  = 90,
    parameter int INIT_STEP  = 10,
    parameter int READ_FIRST = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              EN,
    input  logic              RE,
    input  logic [ADDR_W-1:0] direccion,
    input  logic [DATA_W-1:0] Dato_E,
    output logic [DATA_W-1:0] dato_s,
    output logic              valid,
    output logic              err,
    output logic              busy
);

    // Pattern arithmetic width: wide enough to hold cnt*INIT_STEP exactly.
    localparam int c_pw = DATA_W + ADDR_W;
    // Width of the index into the implemented words.
    localparam int c_iw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // DEPTH may equal 2**ADDR_W, so the range compare needs one extra bit.
    localparam logic [ADDR_W:0]   c_depth = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_last  = ADDR_W'(DEPTH - 1);
    localparam logic              c_write_first = (READ_FIRST == 0);

    localparam logic [0:0] S_INIT  = 1'b0;
    localparam logic [0:0] S_READY = 1'b1;

    logic [DATA_W-1:0] r_mem [0:DEPTH-1];

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [DATA_W-1:0] r_dato_s;
    logic              r_valid;
    logic              r_err;
    logic              r_busy;

    logic              w_in_range;
    logic [c_iw-1:0]   w_idx;
    logic [c_pw-1:0]   w_prod;
    logic [DATA_W-1:0] w_pattern;
    logic              w_we;
    logic [c_iw-1:0]   w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_rdata;

    assign w_in_range = ({1'b0, direccion} < c_depth);
    assign w_idx      = direccion[c_iw-1:0];

    // mem[i] = (INIT_BASE - i*INIT_STEP) mod 2**DATA_W
    assign w_prod    = c_pw'(r_cnt) * c_pw'(INIT_STEP);
    assign w_pattern = DATA_W'(c_pw'(INIT_BASE) - w_prod);

    assign w_rdata = r_mem[w_idx];

    // Write port mux: the sweep owns the array while in INIT, otherwise the
    // user write goes through only for an in-range address.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = w_idx;
        w_wdata = Dato_E;
        if (r_state == S_INIT) begin
            w_we    = 1'b1;
            w_waddr = r_cnt[c_iw-1:0];
            w_wdata = w_pattern;
        end else if (EN && w_in_range) begin
            w_we = 1'b1;
        end
    end

    // The array has no reset. Reset forces the FSM into INIT asynchronously,
    // so a user write in flight when rst rises is dropped; any sweep write
    // made while rst is held lands on word 0 and is rewritten after release.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_INIT;
            r_cnt    <= '0;
            r_dato_s <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
            r_busy   <= 1'b1;
        end else begin
            case (r_state)
                S_INIT: begin
                    // Accesses during the sweep are dropped entirely.
                    r_valid <= 1'b0;
                    r_err   <= 1'b0;
                    if (r_cnt == c_last) begin
                        r_state <= S_READY;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_READY: begin
                    r_busy <= 1'b0;
                    r_err  <= (EN || RE) && !w_in_range;
                    if (RE) begin
                        r_valid <= 1'b1;
                        if (!w_in_range) begin
                            r_dato_s <= '0;
                        end else if (c_write_first && EN) begin
                            r_dato_s <= Dato_E;
                        end else begin
                            r_dato_s <= w_rdata;
                        end
                    end else begin
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_INIT;
                    r_cnt   <= '0;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    assign dato_s = r_dato_s;
    assign valid  = r_valid;
    assign err    = r_err;
    assign busy   = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ram_sinc_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_sinc_param
// Purpose  : Self-checking bench for ram_sinc_param. Two instances share the
//            stimulus: one read-first, one write-first. Expected read results
//            come from a reference word array and go through a scoreboard
//            queue between drive and check.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_sinc_param;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       EN  = 1'b0;
    logic       RE  = 1'b0;
    logic [7:0] direccion = 8'd0;
    logic [7:0] Dato_E    = 8'd0;

    logic [7:0] dato_s_a, dato_s_b;
    logic       valid_a, valid_b, err_a, err_b, busy_a, busy_b;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] da;
        logic [7:0] db;
        logic       v;
        logic       e;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model [0:10];
    logic [7:0] hold_a = 8'd0;
    logic [7:0] hold_b = 8'd0;

    always #5 clk = ~clk;

    ram_sinc_param #(.READ_FIRST(1)) u_dut_rf (
        .clk(clk), .rst(rst), .EN(EN), .RE(RE), .direccion(direccion),
        .Dato_E(Dato_E), .dato_s(dato_s_a), .valid(valid_a), .err(err_a),
        .busy(busy_a)
    );

    ram_sinc_param #(.READ_FIRST(0)) u_dut_wf (
        .clk(clk), .rst(rst), .EN(EN), .RE(RE), .direccion(direccion),
        .Dato_E(Dato_E), .dato_s(dato_s_b), .valid(valid_b), .err(err_b),
        .busy(busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference pattern: 90, 80, ..., 10, 0, 246
    task automatic load_pattern();
        for (int i = 0; i < 11; i++) model[i] = 8'((90 - i * 10) & 255);
    endtask

    // One READY-state access: predict, push, clock, pop, compare.
    task automatic cyc(input string tag, input logic en, input logic re,
                       input logic [7:0] addr, input logic [7:0] din);
        exp_t x;
        bit   inr;
        inr  = (addr < 8'd11);
        x.e  = (en || re) && !inr;
        x.v  = re;
        x.da = hold_a;
        x.db = hold_b;
        if (re) begin
            x.da = inr ? model[addr] : 8'd0;
            x.db = inr ? (en ? din : model[addr]) : 8'd0;
        end
        if (en && inr) model[addr] = din;
        hold_a = x.da;
        hold_b = x.db;
        sb.push_back(x);
        EN = en; RE = re; direccion = addr; Dato_E = din;
        @(posedge clk); #1;
        EN = 1'b0; RE = 1'b0;
        x = sb.pop_front();
        chk({tag, " dato_s rf"}, 32'(dato_s_a), 32'(x.da));
        chk({tag, " dato_s wf"}, 32'(dato_s_b), 32'(x.db));
        chk({tag, " valid"},     32'(valid_a),  32'(x.v));
        chk({tag, " err"},       32'(err_a),    32'(x.e));
        chk({tag, " busy"},      32'(busy_a),   32'd0);
    endtask

    // Count cycles with busy high while hammering EN/RE; accesses must drop.
    task automatic sweep(input string tag);
        int n;
        n = 0;
        EN = 1'b1; RE = 1'b1; direccion = 8'd2; Dato_E = 8'hFF;
        while (busy_a && n < 50) begin
            @(posedge clk); #1;
            n++;
            chk({tag, " busy valid"}, 32'(valid_a), 32'd0);
            chk({tag, " busy err"},   32'(err_a),   32'd0);
        end
        EN = 1'b0; RE = 1'b0;
        chk({tag, " busy cycles"}, 32'(n), 32'd11);
        chk({tag, " busy wf"}, 32'(busy_b), 32'd0);
        hold_a = 8'd0;
        hold_b = 8'd0;
        load_pattern();
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < 11; i++) cyc(tag, 1'b0, 1'b1, 8'(i), 8'h00);
    endtask

    initial begin
        // Reset state
        @(posedge clk); #1;
        chk("reset dato_s", 32'(dato_s_a), 32'd0);
        chk("reset valid",  32'(valid_a),  32'd0);
        chk("reset err",    32'(err_a),    32'd0);
        chk("reset busy",   32'(busy_a),   32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1 + 6: sweep length, dropped accesses, init pattern
        sweep("init1");
        read_all("pattern1");

        // 2: write then read
        cyc("wr3", 1'b1, 1'b0, 8'd3, 8'hA5);
        cyc("rd3", 1'b0, 1'b1, 8'd3, 8'h00);

        // 3: same-cycle read+write, then re-read
        cyc("rw5", 1'b1, 1'b1, 8'd5, 8'h11);
        cyc("rd5", 1'b0, 1'b1, 8'd5, 8'h00);

        // Boundary: last word and its neighbour
        cyc("wr10", 1'b1, 1'b0, 8'd10, 8'h3C);
        cyc("rd10", 1'b0, 1'b1, 8'd10, 8'h00);

        // 4: out-of-range accesses
        cyc("rd11",  1'b0, 1'b1, 8'd11,  8'h00);
        cyc("wr200", 1'b1, 1'b0, 8'd200, 8'h77);
        cyc("idle",  1'b0, 1'b0, 8'd0,   8'h00);
        cyc("rw255", 1'b1, 1'b1, 8'd255, 8'h55);
        read_all("reread");

        // 5: async reset mid-cycle with live outputs
        cyc("pre_rst", 1'b0, 1'b1, 8'd0, 8'h00);
        rst = 1'b1;
        #1;
        chk("async dato_s", 32'(dato_s_a), 32'd0);
        chk("async valid",  32'(valid_a),  32'd0);
        chk("async busy",   32'(busy_a),   32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        // Let the sweep run 5 cycles, then reset again for one cycle
        repeat (5) @(posedge clk);
        #1;
        chk("mid sweep busy", 32'(busy_a), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sweep("init2");
        read_all("pattern2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
